txll_frame_fifo: RTL and testbench

Parametrised single-clock transmit link-layer frame buffer. It accepts SATA FIS words tagged with SOF/EOF from the transport/DMA side and stores them with their framing flags. It presents them first-word-fall-through to the TX link layer. Beyond a plain FIFO, it adds:
- write-side frame integrity checking,
- complete-frame accounting with optional store-and-forward gating,
- a programmable almost-full margin,
- a PHY-reset flush.

---
 rtl/txll_frame_fifo_pkg.sv | 20 ++
 rtl/txll_frame_fifo_ram.sv | 26 ++
 rtl/txll_frame_fifo.sv | 165 ++++++++++++++++
 tb/tb_txll_frame_fifo.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/txll_frame_fifo_pkg.sv
// Shared types and helpers for the TX link-layer frame FIFO.
// Stored entries are laid out as {sof, eof, data}.
package txll_pkg;

    typedef enum logic [0:0] {
        W_IDLE  = 1'b0,
        W_FRAME = 1'b1
    } txll_wstate_e;

    localparam int TXLL_DEF_DATA_WIDTH = 32;

    function automatic int txll_sof_bit(input int data_width);
        return data_width + 1;
    endfunction

    function automatic int txll_eof_bit(input int data_width);
        return data_width;
    endfunction

endpackage

// File: rtl/txll_frame_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
// The asynchronous read is what gives the FIFO its fall-through head.
module txll_fifo_ram #(
    parameter int C_WIDTH      = 34,
    parameter int C_ADDR_WIDTH = 9
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [C_ADDR_WIDTH-1:0] wr_addr,
    input  logic [C_WIDTH-1:0]      wr_data,
    input  logic [C_ADDR_WIDTH-1:0] rd_addr,
    output logic [C_WIDTH-1:0]      rd_data
);

    logic [C_WIDTH-1:0] mem_r [0:(1 << C_ADDR_WIDTH)-1];

    // Storage write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/txll_frame_fifo.sv
// TX link-layer frame buffer: framing checks on the write side, frame
// accounting with optional store-and-forward gating, FWFT read side.
module txll_frame_fifo
    import txll_pkg::*;
#(
    parameter int C_DATA_WIDTH   = TXLL_DEF_DATA_WIDTH,
    parameter int C_ADDR_WIDTH   = 9,
    parameter int C_AFULL_MARGIN = 16,
    parameter int C_STORE_FWD    = 1
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic                    phyreset,
    input  logic                    wr_en,
    input  logic [C_DATA_WIDTH-1:0] wr_data,
    input  logic                    wr_sof,
    input  logic                    wr_eof,
    output logic                    wr_full,
    output logic                    wr_almost_full,
    output logic [C_ADDR_WIDTH:0]   wr_count,
    output logic                    wr_err,
    output logic                    rd_valid,
    input  logic                    rd_en,
    output logic [C_DATA_WIDTH-1:0] rd_data,
    output logic                    rd_sof,
    output logic                    rd_eof,
    output logic                    eof_poped,
    output logic [C_ADDR_WIDTH:0]   frame_count
);

    localparam int CW            = C_ADDR_WIDTH + 1;
    localparam int EW            = C_DATA_WIDTH + 2;
    localparam int DEPTH         = 1 << C_ADDR_WIDTH;
    localparam int TXLL_SOF_BIT  = txll_sof_bit(C_DATA_WIDTH);
    localparam int TXLL_EOF_BIT  = txll_eof_bit(C_DATA_WIDTH);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AFULL = CW'(DEPTH - C_AFULL_MARGIN);
    localparam logic [C_ADDR_WIDTH-1:0] PTR_ZERO = {C_ADDR_WIDTH{1'b0}};
    localparam logic [C_ADDR_WIDTH-1:0] PTR_ONE  = {{(C_ADDR_WIDTH-1){1'b0}}, 1'b1};

    txll_wstate_e            state_r;
    txll_wstate_e            state_nxt_s;
    logic [C_ADDR_WIDTH-1:0] wr_ptr_r;
    logic [C_ADDR_WIDTH-1:0] rd_ptr_r;
    logic [CW-1:0]           wr_count_r;
    logic [CW-1:0]           frame_count_r;
    logic                    wr_err_r;
    logic                    eof_poped_r;

    logic          flush_s;
    logic          full_s;
    logic          rd_valid_s;
    logic          pop_s;
    logic          wr_accept_s;
    logic          wr_drop_s;
    logic          eof_in_s;
    logic          eof_out_s;
    logic [EW-1:0] head_s;

    assign flush_s    = sys_rst | phyreset;
    assign full_s     = (wr_count_r == CNT_DEPTH);
    // In store-and-forward mode a full buffer still drains, otherwise a
    // frame longer than the buffer would deadlock.
    assign rd_valid_s = (wr_count_r != CNT_ZERO) &&
                        ((C_STORE_FWD == 0) || (frame_count_r != CNT_ZERO) || full_s);
    assign pop_s      = rd_en & rd_valid_s;
    assign eof_in_s   = wr_accept_s & wr_eof;
    assign eof_out_s  = pop_s & head_s[TXLL_EOF_BIT];

    txll_fifo_ram #(
        .C_WIDTH      (EW),
        .C_ADDR_WIDTH (C_ADDR_WIDTH)
    ) u_ram (
        .clk     (sys_clk),
        .wr_en   (wr_accept_s),
        .wr_addr (wr_ptr_r),
        .wr_data ({wr_sof, wr_eof, wr_data}),
        .rd_addr (rd_ptr_r),
        .rd_data (head_s)
    );

    // Framing FSM decision: accept or drop the offered word
    always_comb begin
        wr_accept_s = 1'b0;
        wr_drop_s   = 1'b0;
        state_nxt_s = state_r;
        if (wr_en && !flush_s) begin
            if (full_s) begin
                wr_drop_s = 1'b1;
            end else begin
                case (state_r)
                    W_IDLE: begin
                        if (wr_sof) begin
                            wr_accept_s = 1'b1;
                            state_nxt_s = wr_eof ? W_IDLE : W_FRAME;
                        end else begin
                            wr_drop_s = 1'b1;
                        end
                    end
                    W_FRAME: begin
                        if (wr_sof) begin
                            wr_drop_s = 1'b1;
                        end else begin
                            wr_accept_s = 1'b1;
                            state_nxt_s = wr_eof ? W_IDLE : W_FRAME;
                        end
                    end
                    default: begin
                        wr_drop_s   = 1'b1;
                        state_nxt_s = W_IDLE;
                    end
                endcase
            end
        end else begin
            wr_accept_s = 1'b0;
        end
    end

    // Pointers, occupancy/frame counters, FSM state and event pulses
    always_ff @(posedge sys_clk) begin
        if (flush_s) begin
            state_r       <= W_IDLE;
            wr_ptr_r      <= PTR_ZERO;
            rd_ptr_r      <= PTR_ZERO;
            wr_count_r    <= CNT_ZERO;
            frame_count_r <= CNT_ZERO;
            wr_err_r      <= 1'b0;
            eof_poped_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            wr_err_r    <= wr_drop_s;
            eof_poped_r <= eof_out_s;
            if (wr_accept_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({wr_accept_s, pop_s})
                2'b10:   wr_count_r <= wr_count_r + CNT_ONE;
                2'b01:   wr_count_r <= wr_count_r - CNT_ONE;
                default: wr_count_r <= wr_count_r;
            endcase
            case ({eof_in_s, eof_out_s})
                2'b10:   frame_count_r <= frame_count_r + CNT_ONE;
                2'b01:   frame_count_r <= frame_count_r - CNT_ONE;
                default: frame_count_r <= frame_count_r;
            endcase
        end
    end

    assign wr_full        = full_s;
    assign wr_almost_full = (wr_count_r >= CNT_AFULL);
    assign wr_count       = wr_count_r;
    assign wr_err         = wr_err_r;
    assign rd_valid       = rd_valid_s;
    assign rd_data        = head_s[C_DATA_WIDTH-1:0];
    assign rd_sof         = head_s[TXLL_SOF_BIT] & rd_valid_s;
    assign rd_eof         = head_s[TXLL_EOF_BIT] & rd_valid_s;
    assign eof_poped      = eof_poped_r;
    assign frame_count    = frame_count_r;

endmodule

// File: tb/tb_txll_frame_fifo.sv
// Scoreboard bench: one store-and-forward and one cut-through instance;
// expected words are queued on write, a monitor process checks every pop.
module tb_txll_frame_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        sys_rst;
    logic        sf_phyreset, sf_wr_en, sf_wr_sof, sf_wr_eof, sf_rd_en;
    logic [31:0] sf_wr_data, sf_rd_data;
    logic        sf_wr_full, sf_wr_afull, sf_wr_err, sf_rd_valid, sf_rd_sof, sf_rd_eof, sf_eof_poped;
    logic [9:0]  sf_wr_count, sf_frame_count;
    logic        ct_phyreset, ct_wr_en, ct_wr_sof, ct_wr_eof, ct_rd_en;
    logic [31:0] ct_wr_data, ct_rd_data;
    logic        ct_wr_full, ct_wr_afull, ct_wr_err, ct_rd_valid, ct_rd_sof, ct_rd_eof, ct_eof_poped;
    logic [9:0]  ct_wr_count, ct_frame_count;

    int n_cmp = 0;
    int n_mis = 0;
    logic [33:0] q_sf[$];
    logic [33:0] q_ct[$];

    txll_frame_fifo #(.C_STORE_FWD(1)) dut_sf (
        .sys_clk(clk), .sys_rst(sys_rst), .phyreset(sf_phyreset),
        .wr_en(sf_wr_en), .wr_data(sf_wr_data), .wr_sof(sf_wr_sof), .wr_eof(sf_wr_eof),
        .wr_full(sf_wr_full), .wr_almost_full(sf_wr_afull), .wr_count(sf_wr_count),
        .wr_err(sf_wr_err), .rd_valid(sf_rd_valid), .rd_en(sf_rd_en), .rd_data(sf_rd_data),
        .rd_sof(sf_rd_sof), .rd_eof(sf_rd_eof), .eof_poped(sf_eof_poped),
        .frame_count(sf_frame_count)
    );

    txll_frame_fifo #(.C_STORE_FWD(0)) dut_ct (
        .sys_clk(clk), .sys_rst(sys_rst), .phyreset(ct_phyreset),
        .wr_en(ct_wr_en), .wr_data(ct_wr_data), .wr_sof(ct_wr_sof), .wr_eof(ct_wr_eof),
        .wr_full(ct_wr_full), .wr_almost_full(ct_wr_afull), .wr_count(ct_wr_count),
        .wr_err(ct_wr_err), .rd_valid(ct_rd_valid), .rd_en(ct_rd_en), .rd_data(ct_rd_data),
        .rd_sof(ct_rd_sof), .rd_eof(ct_rd_eof), .eof_poped(ct_eof_poped),
        .frame_count(ct_frame_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sf_wr(input logic [31:0] d, input logic s, input logic e, input bit ok);
        sf_wr_en = 1'b1; sf_wr_data = d; sf_wr_sof = s; sf_wr_eof = e;
        if (ok) q_sf.push_back({s, e, d});
        tick();
        sf_wr_en = 1'b0; sf_wr_sof = 1'b0; sf_wr_eof = 1'b0;
    endtask

    task automatic ct_wr(input logic [31:0] d, input logic s, input logic e);
        ct_wr_en = 1'b1; ct_wr_data = d; ct_wr_sof = s; ct_wr_eof = e;
        q_ct.push_back({s, e, d});
        tick();
        ct_wr_en = 1'b0; ct_wr_sof = 1'b0; ct_wr_eof = 1'b0;
    endtask

    task automatic sf_pop(input int n);
        sf_rd_en = 1'b1;
        repeat (n) tick();
        sf_rd_en = 1'b0;
    endtask

    // Scoreboard monitor: a pop happens at the next rising edge whenever
    // rd_en and rd_valid are both high mid-cycle.
    task automatic monitor();
        logic [33:0] exp;
        forever begin
            @(negedge clk);
            if (sf_rd_en && sf_rd_valid) begin
                if (q_sf.size() == 0) begin
                    chk("sf_pop_unexpected", {sf_rd_sof, sf_rd_eof, sf_rd_data[29:0]}, 32'hFFFF_FFFF);
                end else begin
                    exp = q_sf.pop_front();
                    chk("sf_pop_data", sf_rd_data, exp[31:0]);
                    chk("sf_pop_flags", {30'd0, sf_rd_sof, sf_rd_eof}, {30'd0, exp[33:32]});
                end
            end
            if (ct_rd_en && ct_rd_valid) begin
                if (q_ct.size() == 0) begin
                    chk("ct_pop_unexpected", {ct_rd_sof, ct_rd_eof, ct_rd_data[29:0]}, 32'hFFFF_FFFF);
                end else begin
                    exp = q_ct.pop_front();
                    chk("ct_pop_data", ct_rd_data, exp[31:0]);
                    chk("ct_pop_flags", {30'd0, ct_rd_sof, ct_rd_eof}, {30'd0, exp[33:32]});
                end
            end
        end
    endtask

    initial begin
        logic [31:0] d;
        sys_rst = 1'b1;
        sf_phyreset = 1'b0; sf_wr_en = 1'b0; sf_wr_sof = 1'b0; sf_wr_eof = 1'b0;
        sf_rd_en = 1'b0; sf_wr_data = 32'd0;
        ct_phyreset = 1'b0; ct_wr_en = 1'b0; ct_wr_sof = 1'b0; ct_wr_eof = 1'b0;
        ct_rd_en = 1'b0; ct_wr_data = 32'd0;
        fork
            monitor();
        join_none
        tick();
        tick();
        sys_rst = 1'b0;

        // reset state
        chk("rst_wr_count", {22'd0, sf_wr_count}, 32'd0);
        chk("rst_frame_count", {22'd0, sf_frame_count}, 32'd0);
        chk("rst_wr_full", {31'd0, sf_wr_full}, 32'd0);
        chk("rst_wr_afull", {31'd0, sf_wr_afull}, 32'd0);
        chk("rst_wr_err", {31'd0, sf_wr_err}, 32'd0);
        chk("rst_rd_valid", {31'd0, sf_rd_valid}, 32'd0);
        chk("rst_rd_sof", {31'd0, sf_rd_sof}, 32'd0);
        chk("rst_rd_eof", {31'd0, sf_rd_eof}, 32'd0);
        chk("rst_eof_poped", {31'd0, sf_eof_poped}, 32'd0);
        chk("rst_ct_rd_valid", {31'd0, ct_rd_valid}, 32'd0);

        // 4-word frame, store-and-forward
        for (int i = 0; i < 4; i++) begin
            sf_wr(32'hA000_0000 + 32'(i), 1'(i == 0), 1'(i == 3), 1'b1);
            chk("sf_gate_rd_valid", {31'd0, sf_rd_valid}, 32'(i == 3));
        end
        chk("sf_frame_count_1", {22'd0, sf_frame_count}, 32'd1);
        chk("sf_wr_count_4", {22'd0, sf_wr_count}, 32'd4);
        chk("sf_head_sof", {31'd0, sf_rd_sof}, 32'd1);
        sf_rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("sf_eof_poped", {31'd0, sf_eof_poped}, 32'(i == 3));
        end
        sf_rd_en = 1'b0;
        chk("sf_drain_frame", {22'd0, sf_frame_count}, 32'd0);
        chk("sf_drain_count", {22'd0, sf_wr_count}, 32'd0);
        chk("sf_drain_valid", {31'd0, sf_rd_valid}, 32'd0);
        tick();
        chk("sf_eof_poped_once", {31'd0, sf_eof_poped}, 32'd0);

        // same frame, cut-through
        for (int i = 0; i < 4; i++) begin
            ct_wr(32'hB000_0000 + 32'(i), 1'(i == 0), 1'(i == 3));
            chk("ct_rd_valid", {31'd0, ct_rd_valid}, 32'd1);
        end
        ct_rd_en = 1'b1;
        repeat (4) tick();
        ct_rd_en = 1'b0;
        chk("ct_drain_count", {22'd0, ct_wr_count}, 32'd0);
        chk("ct_drain_frame", {22'd0, ct_frame_count}, 32'd0);

        // framing errors
        sf_wr(32'hC000_0000, 1'b0, 1'b0, 1'b0);
        chk("err_idle_nosof", {31'd0, sf_wr_err}, 32'd1);
        chk("err_idle_count", {22'd0, sf_wr_count}, 32'd0);
        tick();
        chk("err_pulse_len", {31'd0, sf_wr_err}, 32'd0);
        sf_wr(32'hC000_0001, 1'b1, 1'b0, 1'b1);
        chk("err_sof_ok", {31'd0, sf_wr_err}, 32'd0);
        sf_wr(32'hC000_0002, 1'b1, 1'b0, 1'b0);
        chk("err_sof_in_frame", {31'd0, sf_wr_err}, 32'd1);
        chk("err_sof_not_stored", {22'd0, sf_wr_count}, 32'd1);
        sf_wr(32'hC000_0003, 1'b0, 1'b1, 1'b1);
        chk("err_eof_frame", {22'd0, sf_frame_count}, 32'd1);
        sf_wr(32'hC000_0004, 1'b1, 1'b1, 1'b1);
        chk("single_word_frame", {22'd0, sf_frame_count}, 32'd2);
        chk("single_word_count", {22'd0, sf_wr_count}, 32'd3);
        sf_pop(3);
        chk("err_drain_count", {22'd0, sf_wr_count}, 32'd0);
        chk("err_drain_frame", {22'd0, sf_frame_count}, 32'd0);

        // simultaneous eof write and eof pop
        sf_wr(32'hD000_0000, 1'b1, 1'b1, 1'b1);
        sf_rd_en = 1'b1;
        sf_wr(32'hD000_0001, 1'b1, 1'b1, 1'b1);
        sf_rd_en = 1'b0;
        chk("sim_wr_count", {22'd0, sf_wr_count}, 32'd1);
        chk("sim_frame_count", {22'd0, sf_frame_count}, 32'd1);
        chk("sim_eof_poped", {31'd0, sf_eof_poped}, 32'd1);
        sf_pop(1);
        chk("sim_drain_count", {22'd0, sf_wr_count}, 32'd0);

        // fill to full without eof, twice, to exercise pointer wrap
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < 512; i++) begin
                d = 32'hE000_0000 | (32'(rep) << 16) | 32'(i);
                sf_wr(d, 1'(i == 0), 1'b0, 1'b1);
                if (i == 494) chk("afull_495", {31'd0, sf_wr_afull}, 32'd0);
                if (i == 495) chk("afull_496", {31'd0, sf_wr_afull}, 32'd1);
                if (i == 510) chk("full_511", {31'd0, sf_wr_full}, 32'd0);
            end
            chk("full_512", {31'd0, sf_wr_full}, 32'd1);
            chk("full_count", {22'd0, sf_wr_count}, 32'd512);
            chk("full_frame0", {22'd0, sf_frame_count}, 32'd0);
            chk("full_rd_valid", {31'd0, sf_rd_valid}, 32'd1);
            sf_wr(32'hEEEE_EEEE, 1'b0, 1'b0, 1'b0);
            chk("overflow_err", {31'd0, sf_wr_err}, 32'd1);
            chk("overflow_count", {22'd0, sf_wr_count}, 32'd512);
            sf_pop(1);
            chk("partial_count", {22'd0, sf_wr_count}, 32'd511);
            chk("partial_gated", {31'd0, sf_rd_valid}, 32'd0);
            sf_wr(32'hEF00_0000 | 32'(rep), 1'b0, 1'b1, 1'b1);
            chk("long_frame_count", {22'd0, sf_frame_count}, 32'd1);
            sf_pop(512);
            chk("wrap_drain_count", {22'd0, sf_wr_count}, 32'd0);
            chk("wrap_drain_frame", {22'd0, sf_frame_count}, 32'd0);
            chk("wrap_eof_poped", {31'd0, sf_eof_poped}, 32'd1);
        end

        // phyreset mid-frame
        sf_wr(32'hF000_0000, 1'b1, 1'b0, 1'b1);
        sf_wr(32'hF000_0001, 1'b0, 1'b0, 1'b1);
        chk("phy_pre_count", {22'd0, sf_wr_count}, 32'd2);
        sf_phyreset = 1'b1; sf_wr_en = 1'b1; sf_wr_data = 32'hF000_0002; sf_rd_en = 1'b1;
        tick();
        sf_phyreset = 1'b0; sf_wr_en = 1'b0; sf_rd_en = 1'b0;
        q_sf.delete();
        chk("phy_count", {22'd0, sf_wr_count}, 32'd0);
        chk("phy_rd_valid", {31'd0, sf_rd_valid}, 32'd0);
        chk("phy_frame", {22'd0, sf_frame_count}, 32'd0);
        chk("phy_no_err", {31'd0, sf_wr_err}, 32'd0);
        sf_wr(32'hF000_0003, 1'b0, 1'b0, 1'b0);
        chk("phy_idle_err", {31'd0, sf_wr_err}, 32'd1);
        chk("phy_idle_count", {22'd0, sf_wr_count}, 32'd0);

        tick();
        chk("sf_queue_left", 32'(q_sf.size()), 32'd0);
        chk("ct_queue_left", 32'(q_ct.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
